ysyx_23060332_lsu: RTL and testbench
====================================

Name: ysyx_23060332_lsu

Overview:
Load/store and writeback unit between the EXU and the register-file write port.
- Accepts one operation at a time from the EXU through a valid/ready handshake.
- Memory ops: performs the access over a variable-latency request/response bus. Loads are aligned and sign/zero-extended, then written back.
- Non-memory ops: forwards the ALU result to the write port.
- Sole driver of waddr/wdata/reg_wen.

Parameters:
- ADDR_W, 32, memory address width
- DATA_W, 32, register/memory data width

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  EXU op valid
- in_ready  out  1  LSU can accept an op
- in_is_load  in  1  op is a load
- in_is_store  in  1  op is a store
- in_funct3  in  3  RV32 width/sign code
- in_addr  in  ADDR_W  effective address
- in_wdata  in  DATA_W  store data (rs2)
- in_alu_result  in  DATA_W  result for non-memory ops
- in_rd  in  5  destination register
- mem_req_valid  out  1  bus request valid
- mem_req_ready  in  1  bus accepts request
- mem_req_addr  out  ADDR_W  word-aligned address (addr[1:0]=0)
- mem_req_wen  out  1  1 = store
- mem_req_wdata  out  DATA_W  lane-replicated store data
- mem_req_wmask  out  4  byte strobes
- mem_resp_valid  in  1  response/ack valid
- mem_resp_rdata  in  DATA_W  load data
- waddr  out  5  register write address
- wdata  out  DATA_W  register write data
- reg_wen  out  1  register write enable
- done  out  1  one-cycle retire pulse
- misalign_err  out  1  one-cycle fault pulse

Behaviour:
- Reset (async, immediate): state=IDLE. All outputs 0 except in_ready=1. Latched op cleared.
- States: IDLE, REQ, WAIT, WB, ERR. in_ready=1 only in IDLE.
- IDLE: on in_valid, latch all in_* fields, then:
  - Fault → ERR: both load and store set; funct3 ∈ {011,110,111} on a memory op; halfword with addr[0]≠0; word with addr[1:0]≠0.
  - Load or store → REQ.
  - Otherwise → WB with wdata=alu_result.
- REQ: mem_req_valid=1, request fields held stable until mem_req_ready. On accept → WAIT. mem_resp_valid is ignored in REQ; the earliest response is the cycle after acceptance.
- WAIT: on mem_resp_valid:
  - Load: capture the extended data into the wdata register → WB.
  - Store: pulse done → IDLE, no register write.
- WB: one cycle. waddr=rd; reg_wen=1 iff rd≠0; done=1 → IDLE.
- ERR: one cycle. misalign_err=1, done=1, no bus request, reg_wen=0 → IDLE.
- Load extract (lane=addr[1:0]):
  - lb/lbu: byte at lane, sign/zero-extended.
  - lh/lhu: halfword at addr[1], sign/zero-extended.
  - lw: the full word.
- Store:
  - sb: wmask=0001<<lane, byte replicated ×4.
  - sh: wmask=0011<<(2·addr[1]), half replicated ×2.
  - sw: wmask=1111.
- Latency from accept cycle N:
  - Non-memory op: WB at N+1.
  - Load with zero-wait bus: REQ N+1, WAIT N+2 (resp), WB N+3.
- mem_resp_valid outside WAIT: ignored. This covers stale responses after a reset.
- waddr/wdata are held at their last values when reg_wen=0.

Decomposition:
- Shared define file: funct3 codes (LB…LHU, SB/SH/SW), FSM state encoding, RegAddrBus/RegDataBus widths.
- One combinational sub-module, ysyx_23060332_lsu_align. Inputs: funct3, addr[1:0], store data, rdata. Outputs: wmask, replicated wdata, extended load data, misalign flag.

Test Plan:
- lb, addr 0x80000003, resp rdata 0x80123456, rd=7 → wdata=0xFFFFFF80, reg_wen pulse. Repeat as lbu → 0x00000080.
- sh, addr 0x00000102, in_wdata 0x1234ABCD → mem_req_addr=0x00000100, wmask=1100, mem_req_wdata=0xABCDABCD. done pulses on the ack; reg_wen never asserts.
- lw, addr 0x104, rd=5; mem_req_ready held low 3 cycles, resp 0xDEADBEEF 2 cycles after accept → request fields stable throughout, in_ready=0 throughout, exactly one reg_wen with waddr=5.
- lw, addr 0x102 → misalign_err and done pulse the cycle after accept; mem_req_valid and reg_wen stay 0.
- Non-memory op, alu_result 0x0000002A, rd=3 → reg_wen at N+1 with wdata=0x2A. Same op with rd=0 → done pulse, reg_wen=0.
- rst asserted mid-WAIT, then mem_resp_valid pulsed → outputs drop to reset values immediately, the response is ignored, and a following lw completes normally.

Source files
------------

// File: rtl/ysyx_23060332_lsu_pkg.sv
// Shared definitions for the load/store/writeback unit: funct3 codes,
// FSM state encoding and register-file bus widths.
package ysyx_23060332_lsu_pkg;

  localparam int REG_ADDR_BUS = 5;
  localparam int REG_DATA_BUS = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_WB   = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  // Width codes that no RV32 load or store uses.
  function automatic logic illegal_width(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/ysyx_23060332_lsu_if.sv
// EXU-side handshake, memory bus and register write port of the LSU.
// master is the LSU's view, slave is the surrounding environment's view.
interface ysyx_23060332_lsu_if
  import ysyx_23060332_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_is_load;
  logic                    in_is_store;
  logic [2:0]              in_funct3;
  logic [ADDR_W-1:0]       in_addr;
  logic [DATA_W-1:0]       in_wdata;
  logic [DATA_W-1:0]       in_alu_result;
  logic [REG_ADDR_BUS-1:0] in_rd;

  logic                    mem_req_valid;
  logic                    mem_req_ready;
  logic [ADDR_W-1:0]       mem_req_addr;
  logic                    mem_req_wen;
  logic [DATA_W-1:0]       mem_req_wdata;
  logic [3:0]              mem_req_wmask;
  logic                    mem_resp_valid;
  logic [DATA_W-1:0]       mem_resp_rdata;

  logic [REG_ADDR_BUS-1:0] waddr;
  logic [DATA_W-1:0]       wdata;
  logic                    reg_wen;
  logic                    done;
  logic                    misalign_err;

  modport master (
    input  in_valid, in_is_load, in_is_store, in_funct3, in_addr, in_wdata,
           in_alu_result, in_rd, mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output in_ready, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata,
           mem_req_wmask, waddr, wdata, reg_wen, done, misalign_err
  );

  modport slave (
    output in_valid, in_is_load, in_is_store, in_funct3, in_addr, in_wdata,
           in_alu_result, in_rd, mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  in_ready, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata,
           mem_req_wmask, waddr, wdata, reg_wen, done, misalign_err
  );

endinterface

// File: rtl/ysyx_23060332_lsu_align.sv
// Byte-lane steering: store strobes/replication, load extraction with
// sign/zero extension, and the alignment/width fault flag.
module ysyx_23060332_lsu_align
  import ysyx_23060332_lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        funct3,
  input  logic [1:0]        lane,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] rdata,
  output logic [3:0]        wmask,
  output logic [DATA_W-1:0] store_rep,
  output logic [DATA_W-1:0] load_ext,
  output logic              misalign
);

  logic        [7:0]  byte_u;
  logic        [15:0] half_u;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  assign byte_u = rdata[{lane, 3'b000} +: 8];
  assign half_u = rdata[{lane[1], 4'b0000} +: 16];
  assign byte_s = signed'(byte_u);
  assign half_s = signed'(half_u);

  always_comb begin
    wmask     = 4'b0000;
    store_rep = '0;
    misalign  = 1'b0;
    case (funct3[1:0])
      F3_SB[1:0]: begin
        wmask     = 4'b0001 << lane;
        store_rep = {4{store_data[7:0]}};
      end
      F3_SH[1:0]: begin
        wmask     = 4'b0011 << {lane[1], 1'b0};
        store_rep = {2{store_data[15:0]}};
        misalign  = lane[0];
      end
      F3_SW[1:0]: begin
        wmask     = 4'b1111;
        store_rep = store_data;
        misalign  = |lane;
      end
      default: misalign = 1'b1;
    endcase
    if (illegal_width(funct3)) misalign = 1'b1;
  end

  always_comb begin
    load_ext = rdata;
    case (funct3)
      F3_LB:   load_ext = DATA_W'(byte_s);
      F3_LBU:  load_ext = DATA_W'(byte_u);
      F3_LH:   load_ext = DATA_W'(half_s);
      F3_LHU:  load_ext = DATA_W'(half_u);
      default: load_ext = rdata;
    endcase
  end

endmodule

// File: rtl/ysyx_23060332_lsu.sv
// Load/store and writeback unit: one op at a time from the EXU, memory ops
// over a variable-latency req/resp bus, sole driver of the register write port.
module ysyx_23060332_lsu
  import ysyx_23060332_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic              clk,
  input logic              rst,
  ysyx_23060332_lsu_if.master bus
);

  state_t state, state_n;

  logic                    is_load_p1;
  logic                    is_store_p1;
  logic [2:0]              funct3_p1;
  logic [ADDR_W-1:0]       addr_p1;
  logic [DATA_W-1:0]       sdata_p1;
  logic [REG_ADDR_BUS-1:0] rd_p1;
  logic [REG_ADDR_BUS-1:0] wb_addr_p2;
  logic [DATA_W-1:0]       wb_data_p2;

  logic              idle;
  logic              in_mem;
  logic              in_fault;
  logic              accept;
  logic              load_resp;
  logic [2:0]        al_funct3;
  logic [1:0]        al_lane;
  logic [3:0]        al_wmask;
  logic [DATA_W-1:0] al_store;
  logic [DATA_W-1:0] al_load;
  logic              al_misalign;

  assign idle      = (state == ST_IDLE);
  assign accept    = idle & bus.in_valid;
  assign load_resp = (state == ST_WAIT) & bus.mem_resp_valid & is_load_p1;

  // In IDLE the aligner judges the incoming op; afterwards it works on the latched one.
  assign al_funct3 = idle ? bus.in_funct3     : funct3_p1;
  assign al_lane   = idle ? bus.in_addr[1:0]  : addr_p1[1:0];

  ysyx_23060332_lsu_align #(.DATA_W(DATA_W)) u_align (
    .funct3     (al_funct3),
    .lane       (al_lane),
    .store_data (sdata_p1),
    .rdata      (bus.mem_resp_rdata),
    .wmask      (al_wmask),
    .store_rep  (al_store),
    .load_ext   (al_load),
    .misalign   (al_misalign)
  );

  assign in_mem   = bus.in_is_load | bus.in_is_store;
  assign in_fault = (bus.in_is_load & bus.in_is_store) | (in_mem & al_misalign);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n            = state;
    bus.in_ready       = idle;
    bus.mem_req_valid  = 1'b0;
    bus.mem_req_addr   = '0;
    bus.mem_req_wen    = 1'b0;
    bus.mem_req_wdata  = '0;
    bus.mem_req_wmask  = 4'b0000;
    bus.waddr          = wb_addr_p2;
    bus.wdata          = wb_data_p2;
    bus.reg_wen        = 1'b0;
    bus.done           = 1'b0;
    bus.misalign_err   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          if (in_fault)    state_n = ST_ERR;
          else if (in_mem) state_n = ST_REQ;
          else             state_n = ST_WB;
        end
      end
      ST_REQ: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_addr  = {addr_p1[ADDR_W-1:2], 2'b00};
        bus.mem_req_wen   = is_store_p1;
        bus.mem_req_wdata = al_store;
        bus.mem_req_wmask = al_wmask;
        if (bus.mem_req_ready) state_n = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.mem_resp_valid) begin
          if (is_load_p1) begin
            state_n = ST_WB;
          end else begin
            bus.done = 1'b1;
            state_n  = ST_IDLE;
          end
        end
      end
      ST_WB: begin
        bus.reg_wen = (rd_p1 != '0);
        bus.done    = 1'b1;
        state_n     = ST_IDLE;
      end
      ST_ERR: begin
        bus.misalign_err = 1'b1;
        bus.done         = 1'b1;
        state_n          = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Stage p1: op latched on accept. Stage p2: write-port registers, touched only
  // when a real register write follows so they hold while reg_wen is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_load_p1  <= 1'b0;
      is_store_p1 <= 1'b0;
      funct3_p1   <= '0;
      addr_p1     <= '0;
      sdata_p1    <= '0;
      rd_p1       <= '0;
      wb_addr_p2  <= '0;
      wb_data_p2  <= '0;
    end else begin
      if (accept) begin
        is_load_p1  <= bus.in_is_load;
        is_store_p1 <= bus.in_is_store;
        funct3_p1   <= bus.in_funct3;
        addr_p1     <= bus.in_addr;
        sdata_p1    <= bus.in_wdata;
        rd_p1       <= bus.in_rd;
        if (!in_mem && (bus.in_rd != '0)) begin
          wb_addr_p2 <= bus.in_rd;
          wb_data_p2 <= bus.in_alu_result;
        end
      end
      if (load_resp && (rd_p1 != '0)) begin
        wb_addr_p2 <= rd_p1;
        wb_data_p2 <= al_load;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060332_lsu.sv
// Randomized bench for the LSU against a byte-lane reference model.
module tb_ysyx_23060332_lsu;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_23060332_lsu_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  ysyx_23060332_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit        ld;
    bit        st;
    bit [2:0]  f3;
    bit [31:0] addr;
    bit [31:0] sdata;
    bit [31:0] alu;
    bit [4:0]  rd;
  } op_t;

  function automatic op_t mk_op(bit ld, bit st, bit [2:0] f3, bit [31:0] addr,
                                bit [31:0] sdata, bit [31:0] alu, bit [4:0] rd);
    op_t o;
    o.ld = ld; o.st = st; o.f3 = f3; o.addr = addr;
    o.sdata = sdata; o.alu = alu; o.rd = rd;
    return o;
  endfunction

  // ---------------- reference model ----------------
  function automatic bit model_fault(op_t o);
    if (o.ld && o.st) return 1'b1;
    if (!(o.ld || o.st)) return 1'b0;
    if (o.f3 == 3 || o.f3 == 6 || o.f3 == 7) return 1'b1;
    if (o.f3 % 4 == 1 && o.addr % 2 != 0) return 1'b1;
    if (o.f3 % 4 == 2 && o.addr % 4 != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit [31:0] model_load(bit [2:0] f3, bit [31:0] addr, bit [31:0] rd_word);
    bit [31:0] b, h;
    b = (rd_word >> (8 * (addr % 4))) % 256;
    h = (rd_word >> (16 * ((addr / 2) % 2))) % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      default: return rd_word;
    endcase
  endfunction

  function automatic bit [3:0] model_mask(bit [2:0] f3, bit [31:0] addr);
    case (f3 % 4)
      0:       return 4'(1 << (addr % 4));
      1:       return (addr % 4 >= 2) ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic bit [31:0] model_swdata(bit [2:0] f3, bit [31:0] sdata);
    case (f3 % 4)
      0:       return (sdata % 256) * 32'h0101_0101;
      1:       return (sdata % 65536) * 32'h0001_0001;
      default: return sdata;
    endcase
  endfunction

  bit [31:0] last_wdata;
  bit [31:0] last_req_addr;
  bit [36:0] last_req_data;

  task automatic drive_idle_inputs();
    bus.in_valid = 1'b0; bus.in_is_load = 1'b0; bus.in_is_store = 1'b0;
    bus.in_funct3 = '0; bus.in_addr = '0; bus.in_wdata = '0;
    bus.in_alu_result = '0; bus.in_rd = '0;
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_rdata = '0;
  endtask

  // Issue one op, act as the memory (stall cycles, then response rdelay cycles
  // after the cycle following acceptance), and check everything the model predicts.
  task automatic do_op(input op_t o, input int stall, input int rdelay, input bit [31:0] rword);
    bit fault, mem, writes;
    bit [31:0] exp_wd;
    bit [31:0] exp_addr;
    bit [36:0] exp_req;
    int acc_k, done_k, n_wen, n_err, n_acc, exp_k;
    fault  = model_fault(o);
    mem    = !fault && (o.ld || o.st);
    writes = !fault && !o.st && (o.rd != 0);
    exp_wd = o.ld ? model_load(o.f3, o.addr, rword) : o.alu;
    exp_addr = o.addr - (o.addr % 4);
    exp_req  = {o.st, model_mask(o.f3, o.addr), model_swdata(o.f3, o.sdata)};
    acc_k = -1; done_k = -1; n_wen = 0; n_err = 0; n_acc = 0;

    @(posedge clk); #1;
    chk("idle_rdy", bus.in_ready, 1'b1);
    bus.in_valid = 1'b1; bus.in_is_load = o.ld; bus.in_is_store = o.st;
    bus.in_funct3 = o.f3; bus.in_addr = o.addr; bus.in_wdata = o.sdata;
    bus.in_alu_result = o.alu; bus.in_rd = o.rd;
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_funct3 = 3'($urandom); bus.in_addr = $urandom; bus.in_wdata = $urandom;
    bus.in_alu_result = $urandom; bus.in_rd = 5'($urandom);

    for (int k = 1; k <= 60 && done_k < 0; k++) begin
      bus.mem_req_ready = (k > stall);
      if (acc_k > 0 && k == acc_k + 1 + rdelay) begin
        bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = rword;
      end else if (acc_k > 0 && k < acc_k + 1 + rdelay) begin
        bus.mem_resp_valid = 1'b0; bus.mem_resp_rdata = $urandom;
      end else begin
        bus.mem_resp_valid = ($urandom % 3 == 0); bus.mem_resp_rdata = $urandom;
      end
      @(negedge clk);
      chk("busy_rdy", bus.in_ready, 1'b0);
      if (bus.mem_req_valid) begin
        chk("req_addr", bus.mem_req_addr, exp_addr);
        chk("req_data", {bus.mem_req_wen, bus.mem_req_wmask, bus.mem_req_wdata}, exp_req);
        last_req_addr = bus.mem_req_addr;
        last_req_data = {bus.mem_req_wen, bus.mem_req_wmask, bus.mem_req_wdata};
        if (bus.mem_req_ready) begin n_acc++; acc_k = k; end
      end
      if (bus.reg_wen) begin
        n_wen++;
        chk("waddr", bus.waddr, o.rd);
        chk("wdata", bus.wdata, exp_wd);
        last_wdata = bus.wdata;
      end
      if (bus.misalign_err) n_err++;
      if (bus.done) done_k = k;
      @(posedge clk); #1;
    end
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;

    if (done_k < 0) chk("timeout", 1'b0, 1'b1);
    if (!mem)      exp_k = 1;
    else if (o.ld) exp_k = acc_k + 2 + rdelay;
    else           exp_k = acc_k + 1 + rdelay;
    chk("done_lat", done_k, exp_k);
    chk("acc_cyc", acc_k, mem ? stall + 1 : -1);
    chk("n_acc", n_acc, mem);
    chk("n_wen", n_wen, writes);
    chk("n_err", n_err, fault);
    @(negedge clk);
    chk("post_quiet", {bus.done, bus.reg_wen, bus.misalign_err, bus.mem_req_valid}, 4'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rdy"}, bus.in_ready, 1'b1);
    chk({tag, "_ctl"}, {bus.mem_req_valid, bus.reg_wen, bus.done, bus.misalign_err,
                        bus.mem_req_wen, bus.mem_req_wmask}, 9'b0);
    chk({tag, "_req"}, {bus.mem_req_addr, bus.mem_req_wdata}, 64'b0);
    chk({tag, "_wb"},  {bus.waddr, bus.wdata}, 37'b0);
  endtask

  initial begin
    op_t o;
    int kind;
    bit [2:0] f3;
    bit [2:0] ld_codes [5];
    ld_codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    rst = 1'b1;
    drive_idle_inputs();
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs("rst0");
    rst = 1'b0;

    // lb / lbu on the top byte lane
    do_op(mk_op(1, 0, 3'b000, 32'h8000_0003, 0, 0, 7), 0, 0, 32'h8012_3456);
    chk("lb_val", last_wdata, 32'hFFFF_FF80);
    do_op(mk_op(1, 0, 3'b100, 32'h8000_0003, 0, 0, 7), 0, 0, 32'h8012_3456);
    chk("lbu_val", last_wdata, 32'h0000_0080);
    // sh in the upper half
    do_op(mk_op(0, 1, 3'b001, 32'h0000_0102, 32'h1234_ABCD, 0, 4), 0, 0, 0);
    chk("sh_addr", last_req_addr, 32'h0000_0100);
    chk("sh_req", last_req_data, {1'b1, 4'b1100, 32'hABCD_ABCD});
    // lw with a stalled request and a delayed response
    do_op(mk_op(1, 0, 3'b010, 32'h0000_0104, 0, 0, 5), 3, 1, 32'hDEAD_BEEF);
    chk("lw_val", last_wdata, 32'hDEAD_BEEF);
    // misaligned lw, then non-memory ops
    do_op(mk_op(1, 0, 3'b010, 32'h0000_0102, 0, 0, 6), 0, 0, 0);
    do_op(mk_op(0, 0, 3'b000, 0, 0, 32'h0000_002A, 3), 0, 0, 0);
    chk("alu_val", last_wdata, 32'h0000_002A);
    do_op(mk_op(0, 0, 3'b000, 0, 0, 32'h0000_0055, 0), 0, 0, 0);

    // reset in the middle of WAIT, then a stale response
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_is_load = 1'b1; bus.in_is_store = 1'b0;
    bus.in_funct3 = 3'b010; bus.in_addr = 32'h200; bus.in_rd = 5'd9;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b0;
    #2 rst = 1'b1;
    #1 chk_reset_outputs("rst_mid");
    @(posedge clk); #1;
    bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stale_resp", {bus.done, bus.reg_wen, bus.mem_req_valid, bus.in_ready}, 4'b0001);
      @(posedge clk); #1;
      bus.mem_resp_valid = 1'b0;
    end
    do_op(mk_op(1, 0, 3'b010, 32'h0000_0208, 0, 0, 10), 0, 0, 32'hCAFE_F00D);
    chk("lw_after_rst", last_wdata, 32'hCAFE_F00D);

    // randomized mix
    for (int i = 0; i < 200; i++) begin
      kind = $urandom % 10;
      o = mk_op(0, 0, 3'($urandom), $urandom, $urandom, $urandom, 5'($urandom));
      if (kind <= 3) begin
        o.ld = 1; o.f3 = ld_codes[$urandom % 5];
      end else if (kind <= 5) begin
        o.st = 1; o.f3 = 3'($urandom % 3);
      end else if (kind == 8) begin
        o.ld = 1; o.st = 1;
      end else if (kind == 9) begin
        o.ld = $urandom % 2; o.st = !o.ld;
        f3 = 3'($urandom % 3); o.f3 = (f3 == 0) ? 3'd3 : ((f3 == 1) ? 3'd6 : 3'd7);
      end
      if ((o.ld || o.st) && ($urandom % 2 == 0)) begin
        if (o.f3 % 4 == 1) o.addr = o.addr - (o.addr % 2);
        if (o.f3 % 4 == 2) o.addr = o.addr - (o.addr % 4);
      end
      do_op(o, $urandom % 4, $urandom % 3, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
